// File: rtl/seg7_pkg.sv
// seg7_pkg: shared BCD type and active-low gfedcba segment patterns.
package seg7_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_lut.sv
// seg7_lut: BCD nibble to active-low segment pattern; non-BCD codes and blank_i give all-off.
module seg7_lut
  import seg7_pkg::*;
(
  input  bcd_t       nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
    if (blank_i) seg_o = SEG_BLANK;
  end
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed BCD display driver with leading-zero suppression.
// Optional per-digit blinking is built when SEG_BLINK_EN is defined.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_tick
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]              seg_q, seg_d, lut_seg;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, wrap, frame_wrap, lz_blank, blink_off;
  bcd_t                    nib;
  // Outputs only change on slot advances, so a load always shows from the next advance on.
  always_comb begin
    wrap       = presc_q == PW'(SCAN_DIV - 1);
    frame_wrap = wrap && idx_q == IW'(NUM_DIGITS - 1);
    presc_d    = wrap ? '0 : presc_q + 1'b1;
    idx_d      = frame_wrap ? '0 : (wrap ? idx_q + 1'b1 : idx_q);
    shadow_d   = load ? digits_in : shadow_q;
    nib        = shadow_q[4*idx_d +: 4];
    lz_blank   = lz_en && idx_d != '0 && (shadow_q >> (4*idx_d)) == '0;
    seg_d      = wrap ? lut_seg : seg_q;
    an_d       = presc_d == PW'(SCAN_DIV - 1) ? '1 : (wrap ? ~(NUM_DIGITS'(1) << idx_d) : an_q);
  end
  seg7_lut u_lut (
    .nibble_i(nib),
    .blank_i (lz_blank || blink_off),
    .seg_o   (lut_seg)
  );
`ifdef SEG_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d, bwrap;
  always_comb begin
    bwrap     = frame_wrap && bcnt_q == BW'(BLINK_DIV - 1);
    bcnt_d    = bwrap ? '0 : (frame_wrap ? bcnt_q + 1'b1 : bcnt_q);
    phase_d   = phase_q ^ bwrap;
    blink_off = phase_d && blink_mask[idx_d];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_off    = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '1;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= frame_wrap;
    end
  assign segments   = seg_q;
  assign anodes     = an_q;
  assign frame_tick = tick_q;
endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clocks per digit slot, minimum 2.
REQ-003 SHALL have parameter BLINK_DIV, default 25, frames per blink half-period, minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port digits_in, input, 4*NUM_DIGITS bits: BCD digits, nibble 0 least significant.
REQ-007 SHALL have port load, input, 1 bit: capture digits_in into the shadow register.
REQ-008 SHALL have port lz_en, input, 1 bit: leading-zero suppression enable.
REQ-009 SHALL have port blink_mask, input, NUM_DIGITS bits: per-digit blink select; used only with SEG_BLINK_EN.
REQ-010 SHALL have port segments, output, 7 bits: active-low, bit order gfedcba.
REQ-011 SHALL have port anodes, output, NUM_DIGITS bits: active-low, one-hot or all-high.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse per completed scan frame.

Function
REQ-013 SHALL count prescaler 0..SCAN_DIV-1 and wrap; on wrap, advance digit index 0..NUM_DIGITS-1, wrapping to 0.
REQ-014 SHALL register segments and anodes; anodes SHALL drive bit[index] low and all other bits high.
REQ-015 SHALL drive all anodes high when prescaler equals SCAN_DIV-1 (one-clock ghosting dead time).
REQ-016 SHALL decode the current nibble: 0 to 1000000, 1 to 1111001, 2 to 0100100, 3 to 0110000, 4 to 0011001, 5 to 0010010, 6 to 0000010, 7 to 1111000, 8 to 0000000, 9 to 0010000, 10-15 to 1111111.
REQ-017 SHALL latch digits_in into the shadow register on any clk edge with load high; the display SHALL read only the shadow register.
REQ-018 When load coincides with a digit advance, the new slot SHALL show the old shadow value; new data SHALL appear from the following advance.
REQ-019 With lz_en high, digit k SHALL be blanked if digits k..NUM_DIGITS-1 are all zero; digit 0 SHALL never be suppressed.
REQ-020 SHALL assert frame_tick for exactly one clock on the edge where the index wraps from NUM_DIGITS-1 to 0.

Reset
REQ-021 Reset SHALL clear the prescaler and index to 0, the shadow register to all 0xF (blank), segments to 1111111, anodes to all ones, and frame_tick and blink state to 0.
REQ-022 Reset asserted mid-frame SHALL take effect immediately (asynchronously); load SHALL be ignored while reset is high.
REQ-023 After reset release, the first advance SHALL occur SCAN_DIV clocks later.

Configuration
REQ-024 With macro SEG_BLINK_EN defined, a frame counter SHALL toggle the blink phase every BLINK_DIV frame_ticks; while the phase is 1, digits with blink_mask set SHALL show 1111111.
REQ-025 Without SEG_BLINK_EN, the blink counter and blink phase SHALL be absent and blink_mask SHALL be ignored.

Structure
REQ-026 Package seg7_pkg SHALL hold the ten digit segment constants, the SEG_BLANK constant (1111111), and the 4-bit bcd_t typedef.
REQ-027 A combinational sub-module seg7_lut (nibble plus blank input to 7-bit pattern) SHALL implement REQ-016; the scanner SHALL instantiate it once.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2)
REQ-028 Reset, then release -> segments 1111111, anodes 1111, first anode change 4 clocks after release.
REQ-029 load with 16'h1234 -> anodes cycle 1110, 1101, 1011, 0111; segments 0011001, 0110000, 0100100, 1111001 respectively; anodes 1111 on each prescaler==3 cycle; frame_tick once per 16 clocks.
REQ-030 lz_en=1, load 16'h0070 -> digits 3 and 2 blank, digit 1 shows 1111000, digit 0 shows 1000000; load 16'h0000 -> only digit 0 lit, showing 1000000.
REQ-031 load 16'h00A5 with lz_en=0 -> digit 1 shows 1111111, digit 0 shows 0010010; load on an advance edge -> that slot shows the old value.
REQ-032 Assert reset mid-frame at index 2 -> outputs reach their reset values without waiting for a clock edge; scanning restarts at index 0.
REQ-033 With SEG_BLINK_EN, blink_mask 0001 -> digit 0 lit in frames 0-1, blank in frames 2-3, lit in frames 4-5; without the macro -> digit 0 always lit.
